// File: rtl/ring_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of i_ring over
// a 2^pWIN_LOG2-cycle window and reports one saturating count per window.
module ring_meter #(
   parameter int pWIN_LOG2 = 10,
   parameter int pCNT_W    = 16,
   parameter int pSETTLE   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ring,
   input  logic [5:0]        i_sel,
   output logic [pCNT_W-1:0] o_count,
   output logic              o_valid,
   output logic              o_ovf,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

   localparam logic [pWIN_LOG2-1:0] WIN_LAST    = '1;
   localparam logic [pWIN_LOG2-1:0] WIN_ONE     = pWIN_LOG2'(1);
   localparam logic [7:0]           SETTLE_LAST = 8'(pSETTLE - 1);
   localparam logic [pCNT_W-1:0]    CNT_MAX     = '1;
   localparam logic [pCNT_W-1:0]    CNT_ZERO    = '0;

   // Returns {saturated, sum}; saturated means an edge arrived with the counter already full.
   function automatic logic [pCNT_W:0] sat_add(input logic [pCNT_W-1:0] a, input logic inc);
      logic [pCNT_W:0] r;
      if (inc && (a == CNT_MAX)) begin
         r = {1'b1, CNT_MAX};
      end else begin
         r = {1'b0, a + {{(pCNT_W-1){1'b0}}, inc}};
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [5:0]          r_sel_q, r_sel_d;
   logic [7:0]          scnt_q, scnt_d;
   logic [pWIN_LOG2-1:0] wcnt_q, wcnt_d;
   logic [pCNT_W-1:0]   ecnt_q, ecnt_d;
   logic                r_sat_q, r_sat_d;
   logic [pCNT_W-1:0]   count_q, count_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic                busy_q, busy_d;
   logic                edge_p;
   logic                chg;
   logic [pCNT_W:0]     acc;

   always_comb begin
      s1_d    = i_ring;
      s2_d    = s1_q;
      s3_d    = s2_q;
      r_sel_d = i_sel;
      state_d = state_q;
      scnt_d  = scnt_q;
      wcnt_d  = wcnt_q;
      ecnt_d  = ecnt_q;
      r_sat_d = r_sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      edge_p  = s2_q & ~s3_q;
      chg     = (i_sel != r_sel_q);
      acc     = sat_add(ecnt_q, edge_p);

      if (chg) begin
         // A new selection invalidates whatever was being measured.
         state_d = (i_sel == 6'd0) ? ST_IDLE : ST_SETTLE;
         scnt_d  = 8'd0;
         wcnt_d  = '0;
         ecnt_d  = CNT_ZERO;
         r_sat_d = 1'b0;
         count_d = CNT_ZERO;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_sel != 6'd0) begin
                  state_d = ST_SETTLE;
                  scnt_d  = 8'd0;
               end
            end
            ST_SETTLE: begin
               if (scnt_q == SETTLE_LAST) begin
                  state_d = ST_MEASURE;
                  wcnt_d  = '0;
                  ecnt_d  = CNT_ZERO;
                  r_sat_d = 1'b0;
               end else begin
                  scnt_d = scnt_q + 8'd1;
               end
            end
            ST_MEASURE: begin
               if (wcnt_q == WIN_LAST) begin
                  // Edge on the final cycle belongs to this window; next window starts gap-free.
                  count_d = acc[pCNT_W-1:0];
                  ovf_d   = r_sat_q | acc[pCNT_W];
                  valid_d = 1'b1;
                  wcnt_d  = '0;
                  ecnt_d  = CNT_ZERO;
                  r_sat_d = 1'b0;
               end else begin
                  wcnt_d  = wcnt_q + WIN_ONE;
                  ecnt_d  = acc[pCNT_W-1:0];
                  r_sat_d = r_sat_q | acc[pCNT_W];
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         r_sel_q <= 6'd0;
         scnt_q  <= 8'd0;
         wcnt_q  <= '0;
         ecnt_q  <= CNT_ZERO;
         r_sat_q <= 1'b0;
         count_q <= CNT_ZERO;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         r_sel_q <= r_sel_d;
         scnt_q  <= scnt_d;
         wcnt_q  <= wcnt_d;
         ecnt_q  <= ecnt_d;
         r_sat_q <= r_sat_d;
         count_q <= count_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   assign o_count = count_q;
   assign o_valid = valid_q;
   assign o_ovf   = ovf_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_ring_meter.sv
// Bench for ring_meter: two instances (16-bit and 8-bit counters) share stimulus;
// expected windows are queued when stimulus is applied and popped on each o_valid.
module tb_ring_meter;

   localparam int N   = 1024;
   localparam int SET = 16;
   localparam int LAT = 1 + SET + N;

   typedef struct {
      int cnt;
      int tol;
      bit ovf;
      bit ovf_any;
      int cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [5:0]  sel;
   logic        ring;
   logic        ring_man;
   logic        ring_gen;
   int          ring_div;
   int          rcnt;

   logic [15:0] a_count;
   logic        a_valid, a_ovf, a_busy;
   logic [7:0]  b_count;
   logic        b_valid, b_ovf, b_busy;

   int   cyc;
   int   checks;
   int   failures;
   exp_t qa[$];
   exp_t qb[$];

   assign ring = (ring_div == 0) ? ring_man : ring_gen;

   ring_meter #(.pWIN_LOG2(10), .pCNT_W(16), .pSETTLE(SET)) u_a (
      .i_clk(clk), .i_rst(rst), .i_ring(ring), .i_sel(sel),
      .o_count(a_count), .o_valid(a_valid), .o_ovf(a_ovf), .o_busy(a_busy)
   );

   ring_meter #(.pWIN_LOG2(10), .pCNT_W(8), .pSETTLE(SET)) u_b (
      .i_clk(clk), .i_rst(rst), .i_ring(ring), .i_sel(sel),
      .o_count(b_count), .o_valid(b_valid), .o_ovf(b_ovf), .o_busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic void push_a(input int c, input int cnt, input int tol, input bit ovf, input bit any);
      exp_t e;
      e.cyc = c; e.cnt = cnt; e.tol = tol; e.ovf = ovf; e.ovf_any = any;
      qa.push_back(e);
   endfunction

   function automatic void push_b(input int c, input int cnt, input int tol, input bit ovf, input bit any);
      exp_t e;
      e.cyc = c; e.cnt = cnt; e.tol = tol; e.ovf = ovf; e.ovf_any = any;
      qb.push_back(e);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic mon_cmp(input string tag, input bit have, input exp_t e,
                          input logic [31:0] cnt, input logic ovf);
      logic [31:0] lo, hi;
      checks++;
      assert (have === 1'b1) else begin
         failures++;
         $error("FAIL %s_unexpected_valid observed=valid@%0d expected=none", tag, cyc);
      end
      if (have) begin
         lo = 32'(e.cnt - e.tol);
         hi = 32'(e.cnt + e.tol);
         checks++;
         assert (cyc === e.cyc) else begin
            failures++;
            $error("FAIL %s_valid_cycle observed=%0d expected=%0d", tag, cyc, e.cyc);
         end
         checks++;
         assert ((cnt >= lo) && (cnt <= hi)) else begin
            failures++;
            $error("FAIL %s_count observed=%0d expected=%0d+-%0d", tag, cnt, e.cnt, e.tol);
         end
         if (!e.ovf_any) begin
            checks++;
            assert (ovf === e.ovf) else begin
               failures++;
               $error("FAIL %s_ovf observed=%0d expected=%0d", tag, ovf, e.ovf);
            end
         end
      end
   endtask

   // One clock: sample just after the edge, score any output window, advance the ring source.
   task automatic tick();
      bit   have;
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (a_valid === 1'b1) begin
         have = (qa.size() > 0);
         if (have) e = qa.pop_front();
         mon_cmp("win_a", have, e, 32'(a_count), a_ovf);
      end
      if (b_valid === 1'b1) begin
         have = (qb.size() > 0);
         if (have) e = qb.pop_front();
         mon_cmp("win_b", have, e, 32'(b_count), b_ovf);
      end
      if (ring_div != 0) begin
         if (rcnt >= ring_div / 2 - 1) begin
            ring_gen = ~ring_gen;
            rcnt     = 0;
         end else begin
            rcnt++;
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      int c, v0;
      cyc = 0; checks = 0; failures = 0;
      rst = 1'b1; sel = 6'd0; ring_div = 0; rcnt = 0; ring_man = 1'b0; ring_gen = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_a_count", 32'(a_count), 0);
      chk("rst_a_valid", 32'(a_valid), 0);
      chk("rst_a_ovf",   32'(a_ovf),   0);
      chk("rst_a_busy",  32'(a_busy),  0);
      chk("rst_b_count", 32'(b_count), 0);
      chk("rst_b_busy",  32'(b_busy),  0);
      rst = 1'b0;
      tick();
      chk("idle_busy", 32'(a_busy), 0);

      // clk/4 ring, three windows, then selection change at wcnt=500
      c = cyc; ring_div = 4; sel = 6'b000010;
      push_a(c + LAT, 256, 1, 1'b0, 1'b0);
      push_b(c + LAT, 255, 0, 1'b1, 1'b1);
      for (int j = 1; j < 3; j++) begin
         push_a(c + LAT + j * N, 256, 0, 1'b0, 1'b0);
         push_b(c + LAT + j * N, 255, 0, 1'b1, 1'b0);
      end
      wait_until(c + 20);
      chk("settle_busy", 32'(a_busy), 1);
      wait_until(c + LAT + 2 * N + 500);

      c = cyc; sel = 6'b000100;
      tick();
      chk("abort_a_count", 32'(a_count), 0);
      chk("abort_b_count", 32'(b_count), 0);
      chk("abort_b_ovf",   32'(b_ovf),   0);
      chk("abort_busy",    32'(a_busy),  1);
      chk("abort_valid",   32'(a_valid), 0);
      push_a(c + LAT, 256, 1, 1'b0, 1'b0);
      push_b(c + LAT, 255, 0, 1'b1, 1'b1);
      push_a(c + LAT + N, 256, 0, 1'b0, 1'b0);
      push_b(c + LAT + N, 255, 0, 1'b1, 1'b0);
      wait_until(c + LAT + N + 10);

      // clk/2 ring: the 8-bit instance saturates
      c = cyc; ring_div = 2; sel = 6'b001000;
      push_a(c + LAT, 512, 1, 1'b0, 1'b0);
      push_b(c + LAT, 255, 0, 1'b1, 1'b0);
      push_a(c + LAT + N, 512, 0, 1'b0, 1'b0);
      push_b(c + LAT + N, 255, 0, 1'b1, 1'b0);
      wait_until(c + LAT + N + 10);

      // clk/16 ring: saturation clears after reselect
      c = cyc; ring_div = 16; sel = 6'b010000;
      push_a(c + LAT, 64, 1, 1'b0, 1'b0);
      push_b(c + LAT, 64, 1, 1'b0, 1'b0);
      push_a(c + LAT + N, 64, 0, 1'b0, 1'b0);
      push_b(c + LAT + N, 64, 0, 1'b0, 1'b0);
      wait_until(c + LAT + N + 10);

      // Single edges landing on the last cycle of window 1 and the first cycle of window 3
      c = cyc; ring_div = 0; ring_man = 1'b0; sel = 6'b100000;
      v0 = c + LAT;
      for (int j = 0; j < 5; j++) begin
         push_a(v0 + j * N, j % 2, 0, 1'b0, 1'b0);
         push_b(v0 + j * N, j % 2, 0, 1'b0, 1'b0);
      end
      wait_until(v0 + N - 3);     ring_man = 1'b1;
      wait_until(v0 + N + 100);   ring_man = 1'b0;
      wait_until(v0 + 2 * N - 2); ring_man = 1'b1;
      wait_until(v0 + 2 * N + 100); ring_man = 1'b0;
      wait_until(v0 + 4 * N + 10);

      // One-cycle reset at wcnt=700
      ring_div = 4;
      wait_until(v0 + 4 * N + 700);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_a_count", 32'(a_count), 0);
      chk("midrst_a_valid", 32'(a_valid), 0);
      chk("midrst_a_ovf",   32'(a_ovf),   0);
      chk("midrst_a_busy",  32'(a_busy),  0);
      chk("midrst_b_busy",  32'(b_busy),  0);
      c = cyc;
      push_a(c + LAT, 256, 1, 1'b0, 1'b0);
      push_b(c + LAT, 255, 0, 1'b1, 1'b1);
      push_a(c + LAT + N, 256, 0, 1'b0, 1'b0);
      push_b(c + LAT + N, 255, 0, 1'b1, 1'b0);
      wait_until(c + 30);
      chk("remeasure_busy", 32'(a_busy), 1);
      wait_until(c + LAT + N + 10);

      // Deselect with ring still toggling: stays idle, no windows
      c = cyc; sel = 6'd0;
      tick();
      chk("desel_busy",    32'(a_busy),  0);
      chk("desel_a_count", 32'(a_count), 0);
      chk("desel_b_count", 32'(b_count), 0);
      wait_until(c + 5000);
      chk("idle5k_a_busy",  32'(a_busy),  0);
      chk("idle5k_b_busy",  32'(b_busy),  0);
      chk("idle5k_a_valid", 32'(a_valid), 0);

      chk("pending_a", 32'(qa.size()), 0);
      chk("pending_b", 32'(qb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
